// File: rtl/vip_pkg.sv
// Shared definitions for the vector inner-product datapath and its users:
// element width and the controller state encoding.
package vip_pkg;

  localparam int WORD_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } vip_state_e;

endpackage : vip_pkg

// File: rtl/vip_mac.sv
// Combinational multiply-accumulate: sum = acc + a*b, all modulo 2^WORD_WIDTH.
// Only the low word of the product and of the sum is kept, so signed and
// unsigned operands give the same bit pattern.
module vip_mac
  import vip_pkg::*;
(
  input  logic [WORD_WIDTH-1:0] acc_i,
  input  logic [WORD_WIDTH-1:0] a_i,
  input  logic [WORD_WIDTH-1:0] b_i,
  output logic [WORD_WIDTH-1:0] sum_o
);

  logic [WORD_WIDTH-1:0] prod_s;

  // Truncated product followed by truncated add.
  always_comb begin
    prod_s = a_i * b_i;
    sum_o  = acc_i + prod_s;
  end

endmodule : vip_mac

// File: rtl/vector_inner_product.sv
// Inner product of two p-element vectors. Both vectors are captured together
// on a strobe handshake, then one element pair is accumulated per clock.
// The result is held with a strobe until the consumer acknowledges it.
module vector_inner_product
  import vip_pkg::*;
#(
  parameter  int p          = 16,
  localparam int word_width = WORD_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [0:p*word_width-1]   vip_row,
  input  logic                      vip_row_stb,
  output logic                      vip_row_ack,
  input  logic [0:p*word_width-1]   vip_column,
  input  logic                      vip_column_stb,
  output logic                      vip_column_ack,
  output logic [0:word_width-1]     vip_result,
  output logic                      vip_result_stb,
  input  logic                      vip_result_ack
);

  // Index width is at least one bit so p=1 still has a legal counter.
  localparam int               IDX_W    = (p > 1) ? $clog2(p) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(p - 1);

  vip_state_e                state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [word_width-1:0]     acc_q, acc_d;
  logic [0:p*word_width-1]   row_q, row_d;
  logic [0:p*word_width-1]   col_q, col_d;
  logic                      ack_q, ack_d;
  logic [word_width-1:0]     result_q, result_d;
  logic                      result_stb_q, result_stb_d;

  logic [word_width-1:0]     row_elem_s;
  logic [word_width-1:0]     col_elem_s;
  logic [word_width-1:0]     mac_sum_s;

  // Select the current element pair from the captured vectors.
  always_comb begin
    row_elem_s = row_q[int'(idx_q)*word_width +: word_width];
    col_elem_s = col_q[int'(idx_q)*word_width +: word_width];
  end

  vip_mac u_mac (
    .acc_i (acc_q),
    .a_i   (row_elem_s),
    .b_i   (col_elem_s),
    .sum_o (mac_sum_s)
  );

  // Next-state and datapath control; every register holds unless updated.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    acc_d        = acc_q;
    row_d        = row_q;
    col_d        = col_q;
    ack_d        = 1'b0;
    result_d     = result_q;
    result_stb_d = result_stb_q;

    case (state_q)
      IDLE: begin
        // Capture only when both vectors are offered in the same cycle.
        if (vip_row_stb && vip_column_stb) begin
          row_d   = vip_row;
          col_d   = vip_column;
          acc_d   = {word_width{1'b0}};
          idx_d   = {IDX_W{1'b0}};
          ack_d   = 1'b1;
          state_d = CALC;
        end else begin
          state_d = IDLE;
        end
      end

      CALC: begin
        acc_d = mac_sum_s;
        if (idx_q == LAST_IDX) begin
          result_d     = mac_sum_s;
          result_stb_d = 1'b1;
          idx_d        = {IDX_W{1'b0}};
          state_d      = DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = CALC;
        end
      end

      DONE: begin
        // Capture is deliberately not allowed on the release edge.
        if (vip_result_ack) begin
          result_stb_d = 1'b0;
          state_d      = IDLE;
        end else begin
          state_d = DONE;
        end
      end

      default: begin
        result_stb_d = 1'b0;
        state_d      = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= {IDX_W{1'b0}};
      acc_q        <= {word_width{1'b0}};
      row_q        <= {(p*word_width){1'b0}};
      col_q        <= {(p*word_width){1'b0}};
      ack_q        <= 1'b0;
      result_q     <= {word_width{1'b0}};
      result_stb_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      acc_q        <= acc_d;
      row_q        <= row_d;
      col_q        <= col_d;
      ack_q        <= ack_d;
      result_q     <= result_d;
      result_stb_q <= result_stb_d;
    end
  end

  assign vip_row_ack    = ack_q;
  assign vip_column_ack = ack_q;
  assign vip_result     = result_q;
  assign vip_result_stb = result_stb_q;

endmodule : vector_inner_product

// File: tb/tb_vector_inner_product.sv
// Directed bench for vector_inner_product with p=4: expected results are
// queued at capture time and compared when the result strobe appears.
module tb_vector_inner_product;
  import vip_pkg::*;

  localparam int P = 4;
  localparam int W = WORD_WIDTH;

  typedef logic [W-1:0] vec_t [P];

  logic               clk = 1'b0;
  logic               rst;
  logic [0:P*W-1]     vip_row;
  logic               vip_row_stb;
  logic               vip_row_ack;
  logic [0:P*W-1]     vip_column;
  logic               vip_column_stb;
  logic               vip_column_ack;
  logic [0:W-1]       vip_result;
  logic               vip_result_stb;
  logic               vip_result_ack;

  int                 n_cmp = 0;
  int                 n_err = 0;
  int                 cyc   = 0;
  logic [W-1:0]       exp_q [$];

  vector_inner_product #(.p(P)) dut (
    .clk            (clk),
    .rst            (rst),
    .vip_row        (vip_row),
    .vip_row_stb    (vip_row_stb),
    .vip_row_ack    (vip_row_ack),
    .vip_column     (vip_column),
    .vip_column_stb (vip_column_stb),
    .vip_column_ack (vip_column_ack),
    .vip_result     (vip_result),
    .vip_result_stb (vip_result_stb),
    .vip_result_ack (vip_result_ack)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Edge counter used to measure transaction period.
  always @(posedge clk) cyc <= cyc + 1;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #1000000;
    $display("FAIL watchdog: observed no finish, expected finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [0:P*W-1] pack(input vec_t v);
    logic [0:P*W-1] r;
    for (int k = 0; k < P; k++) r[k*W +: W] = v[k];
    return r;
  endfunction

  function automatic logic [W-1:0] dot(input vec_t r, input vec_t c);
    logic [W-1:0] s;
    logic [W-1:0] pr;
    s = '0;
    for (int k = 0; k < P; k++) begin
      pr = r[k] * c[k];
      s  = s + pr;
    end
    return s;
  endfunction

  // Offer both vectors and expect the acknowledge one edge later.
  task automatic start_capture(input vec_t r, input vec_t c, input bit push, input bit hold);
    vip_row        = pack(r);
    vip_column     = pack(c);
    vip_row_stb    = 1'b1;
    vip_column_stb = 1'b1;
    if (push) exp_q.push_back(dot(r, c));
    @(posedge clk); #1;
    check("capture_ack", 64'({vip_row_ack, vip_column_ack}), 64'(2'b11));
    if (!hold) begin
      vip_row_stb    = 1'b0;
      vip_column_stb = 1'b0;
    end
  endtask

  // Wait (bounded) for the result, compare it, hold, then acknowledge.
  task automatic finish_txn(input int ack_delay);
    int           lat;
    logic [W-1:0] exp_v;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) check("ack_one_cycle", 64'({vip_row_ack, vip_column_ack}), 64'(2'b00));
    end while (!vip_result_stb && lat < 50);
    check("result_latency", 64'(lat), 64'(P));
    if (exp_q.size() > 0) exp_v = exp_q.pop_front();
    else exp_v = 'x;
    check("result_value", 64'(vip_result), 64'(exp_v));
    repeat (ack_delay) begin
      @(posedge clk); #1;
      check("done_hold", 64'({vip_result_stb, vip_row_ack, vip_column_ack, vip_result}),
            64'({1'b1, 2'b00, exp_v}));
    end
    vip_result_ack = 1'b1;
    @(posedge clk); #1;
    vip_result_ack = 1'b0;
    check("stb_drop", 64'({vip_result_stb, vip_result}), 64'({1'b0, exp_v}));
  endtask

  initial begin
    int t0;
    rst            = 1'b1;
    vip_row        = '0;
    vip_column     = '0;
    vip_row_stb    = 1'b0;
    vip_column_stb = 1'b0;
    vip_result_ack = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 64'({vip_row_ack, vip_column_ack, vip_result_stb, vip_result}), 64'(0));
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_no_ack", 64'({vip_row_ack, vip_column_ack, vip_result_stb}), 64'(3'b000));

    // Basic product.
    start_capture('{32'd1, 32'd2, 32'd3, 32'd4}, '{32'd5, 32'd6, 32'd7, 32'd8}, 1'b1, 1'b0);
    finish_txn(0);
    check("result_70", 64'(vip_result), 64'(32'd70));

    // Signed elements.
    start_capture('{32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFD, 32'd4}, '{32'd5, 32'd5, 32'd5, 32'd5}, 1'b1, 1'b0);
    finish_txn(0);
    check("result_signed", 64'(vip_result), 64'(32'h0000_000A));

    // Product wrap.
    start_capture('{32'h0001_0000, 32'd0, 32'd0, 32'd0}, '{32'h0001_0000, 32'd0, 32'd0, 32'd0}, 1'b1, 1'b0);
    finish_txn(0);
    check("result_prod_wrap", 64'(vip_result), 64'(32'h0000_0000));

    // Sum wrap.
    start_capture('{32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0}, '{32'd1, 32'd1, 32'd0, 32'd0}, 1'b1, 1'b0);
    finish_txn(0);
    check("result_sum_wrap", 64'(vip_result), 64'(32'h0000_0000));

    // Row strobe alone must not capture.
    vip_row     = pack('{32'd2, 32'd3, 32'd0, 32'd0});
    vip_row_stb = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      check("single_stb_no_ack", 64'({vip_row_ack, vip_column_ack, vip_result_stb}), 64'(3'b000));
    end
    start_capture('{32'd2, 32'd3, 32'd0, 32'd0}, '{32'd7, 32'd1, 32'd0, 32'd0}, 1'b1, 1'b0);
    finish_txn(0);
    check("result_17", 64'(vip_result), 64'(32'd17));

    // Reset on the second CALC cycle aborts the transaction.
    start_capture('{32'd9, 32'd9, 32'd9, 32'd9}, '{32'd9, 32'd9, 32'd9, 32'd9}, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_outputs", 64'({vip_row_ack, vip_column_ack, vip_result_stb, vip_result}), 64'(0));
    repeat (P + 2) begin
      @(posedge clk); #1;
      check("abort_no_stb", 64'({vip_row_ack, vip_column_ack, vip_result_stb}), 64'(3'b000));
    end
    start_capture('{32'd1, 32'd1, 32'd1, 32'd1}, '{32'd1, 32'd2, 32'd3, 32'd4}, 1'b1, 1'b0);
    finish_txn(0);
    check("result_after_abort", 64'(vip_result), 64'(32'd10));

    // Back-to-back with strobes held: minimum period, then withheld ack.
    start_capture('{32'd3, 32'd0, 32'd0, 32'd1}, '{32'd4, 32'd0, 32'd0, 32'd2}, 1'b1, 1'b1);
    t0 = cyc;
    vip_row    = pack('{32'd5, 32'd6, 32'd0, 32'd0});
    vip_column = pack('{32'd1, 32'd1, 32'd1, 32'd1});
    exp_q.push_back(32'd11);
    finish_txn(0);
    check("no_same_edge_capture", 64'({vip_row_ack, vip_column_ack}), 64'(2'b00));
    @(posedge clk); #1;
    check("next_capture_ack", 64'({vip_row_ack, vip_column_ack}), 64'(2'b11));
    check("min_period", 64'(cyc - t0), 64'(P + 2));

    vip_row    = pack('{32'h8000_0000, 32'h8000_0000, 32'd0, 32'd0});
    vip_column = pack('{32'd2, 32'd1, 32'd0, 32'd0});
    exp_q.push_back(32'h8000_0000);
    finish_txn(20);
    check("withheld_no_same_edge", 64'({vip_row_ack, vip_column_ack}), 64'(2'b00));
    @(posedge clk); #1;
    check("withheld_next_capture", 64'({vip_row_ack, vip_column_ack}), 64'(2'b11));
    vip_row_stb    = 1'b0;
    vip_column_stb = 1'b0;
    finish_txn(0);

    check("queue_empty", 64'(exp_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_vector_inner_product

// File: doc/vector_inner_product.md
VECTOR_INNER_PRODUCT -- requirements
Module: vector_inner_product

Interface
REQ-001 SHALL have parameter p, default 16: number of 32-bit elements per vector; legal range 1..256.
REQ-002 SHALL have localparam word_width, fixed 32: element and result width in bits.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous active-high reset.
REQ-006 SHALL have port vip_row, input, [0:p*word_width-1]: row vector; element k at bits [k*word_width +: word_width].
REQ-007 SHALL have port vip_row_stb, input, 1: row vector valid.
REQ-008 SHALL have port vip_row_ack, output, 1: row vector accepted.
REQ-009 SHALL have port vip_column, input, [0:p*word_width-1]: column vector; same element packing as vip_row.
REQ-010 SHALL have port vip_column_stb, input, 1: column vector valid.
REQ-011 SHALL have port vip_column_ack, output, 1: column vector accepted.
REQ-012 SHALL have port vip_result, output, [0:word_width-1]: inner product.
REQ-013 SHALL have port vip_result_stb, output, 1: vip_result valid.
REQ-014 SHALL have port vip_result_ack, input, 1: consumer has taken vip_result.

Function
REQ-015 SHALL implement a three-state FSM: IDLE, CALC, DONE.
REQ-016 In IDLE, on an edge with vip_row_stb=1 and vip_column_stb=1, SHALL capture both vectors into internal registers, clear the accumulator and the element index to 0, and enter CALC (the capture edge).
REQ-017 SHALL drive vip_row_ack and vip_column_ack high together for exactly the one cycle following the capture edge, and low at all other times.
REQ-018 In IDLE with only one strobe high, SHALL neither capture nor acknowledge, and SHALL wait indefinitely.
REQ-019 In CALC, SHALL perform one multiply-accumulate per edge, acc <= acc + row[idx]*column[idx], using the captured copies, then increment idx.
REQ-020 Arithmetic SHALL be 32-bit two's complement; the product and the sum SHALL each be truncated to the low 32 bits (modulo 2^32, no saturation, no overflow flag).
REQ-021 On the CALC edge with idx=p-1, SHALL load vip_result with the final sum, assert vip_result_stb, and enter DONE; vip_result_stb therefore rises on the p-th edge after the capture edge (p=1 included).
REQ-022 In DONE, SHALL hold vip_result and vip_result_stb=1 stable until an edge samples vip_result_ack=1; on that edge it SHALL clear vip_result_stb and return to IDLE.
REQ-023 vip_result SHALL keep its last value after vip_result_stb drops, until the next load or reset.
REQ-024 Strobes and vector inputs SHALL be ignored outside IDLE; they need not be held after the ack cycle.
REQ-025 vip_result_ack SHALL be ignored outside DONE.
REQ-026 If both strobes are high on the DONE to IDLE edge, capture SHALL occur on the following edge, not the same edge; the minimum transaction period is p+2 cycles.

Reset
REQ-027 On an edge with rst=1, SHALL enter IDLE; vip_row_ack=0, vip_column_ack=0, vip_result_stb=0, vip_result=0, accumulator=0, idx=0.
REQ-028 Reset in CALC or DONE SHALL abort the transaction with no result strobe; rst SHALL take priority over all other inputs.

Structure
REQ-029 Package vip_pkg SHALL hold WORD_WIDTH=32 and the state encoding (IDLE, CALC, DONE); the matrix_multiplier SHALL share the same package.
REQ-030 A sub-module vip_mac SHALL implement the combinational 32-bit multiply-add, acc + a*b truncated to 32 bits; the FSM, index counter and registers SHALL stay in vector_inner_product.

Verification
REQ-031 p=4, row [1,2,3,4], column [5,6,7,8], vip_result_ack high on the first DONE cycle -> one-cycle acks; vip_result_stb on the 4th edge after capture; vip_result=70.
REQ-032 p=4, row [-1,2,-3,4], column [5,5,5,5] -> vip_result=10 (0x0000000A).
REQ-033 p=4, row [0x00010000,0,0,0], column [0x00010000,0,0,0] -> vip_result=0x00000000 (wrap); row [0xFFFFFFFF,1,0,0], column [1,1,0,0] -> 0x00000000.
REQ-034 vip_row_stb high alone for 10 cycles -> no ack, no capture; vip_column_stb then raised -> capture and acks on the next edge.
REQ-035 rst pulsed on the 2nd CALC cycle -> all outputs 0 and no vip_result_stb; next transaction row [1,1,1,1], column [1,2,3,4] -> 10.
REQ-036 vip_result_ack withheld 20 cycles with strobes held high -> vip_result_stb and vip_result stable; after ack, new capture 1 edge after the DONE to IDLE edge; period p+2.
